// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, default parameters and helpers for the round-robin
// mux arbiter and its rotating priority encoder.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_HOLD_MAX = 16;

    // Widest one-hot vector onehot_to_idx accepts; arbiters wider than this are rejected at elaboration.
    localparam int ONEHOT_W = 32;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic int unsigned onehot_to_idx(input logic [ONEHOT_W-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (onehot[i]) begin
                idx = int'(unsigned'(i));
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. Returns the first requester
// at or after ptr (wrapping mod N). Independent of any arbiter state, so it can
// be reused by other arbiters.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] winner,
    output logic          valid
);

    // Scan from the farthest offset back to ptr so the nearest requester is the last (winning) assignment.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = |req;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                winner = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner of a shared N:1 mux channel. Grants one
// requester at a time, drives the mux select from the owner and inserts a
// one-cycle turnaround (GAP) between owners so the select never glitches.
// Optional grant timeout is compiled in with the macro MUX_ARB_TIMEOUT_EN;
// without it grants last as long as the owner keeps requesting.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX,
    localparam int SW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [SW-1:0] sel_o,
    output logic          busy_o,
    output logic          timeout_o
);

    if (N < 2 || N > ONEHOT_W || HOLD_MAX < 2) begin : g_bad_params
        $error("mux_arbiter: illegal parameters N=%0d HOLD_MAX=%0d", N, HOLD_MAX);
    end

    arb_state_t    state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] winner;
    logic          win_valid;
    logic [SW-1:0] owner;
    logic          owner_req;
    logic [SW-1:0] ptr_after;

    rr_pick #(.N(N)) u_pick (
        .req    (req_i),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    // The owner is recovered from the registered grant so it can only be valid while a grant is held.
    assign owner     = SW'(onehot_to_idx(ONEHOT_W'(gnt_o)));
    assign owner_req = req_i[owner];
    assign ptr_after = (owner == SW'(N - 1)) ? '0 : owner + 1'b1;
    assign busy_o    = |gnt_o;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HCW = $clog2(HOLD_MAX);

    logic [HCW-1:0] hold_cnt;
    logic           timeout_hit;

    assign timeout_hit = owner_req && (hold_cnt == HCW'(HOLD_MAX - 1));

    // Count cycles of the current grant (saturating) and pulse timeout_o on the edge that revokes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= (state == OWN) && timeout_hit;
            if (state != OWN) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HCW'(HOLD_MAX - 1)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    logic timeout_hit;

    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Arbitrate in IDLE/GAP, hold the grant in OWN, and spend exactly one GAP cycle after every release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt_o <= '0;
            sel_o <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                OWN: begin
                    if (!owner_req || timeout_hit) begin
                        gnt_o <= '0;
                        ptr   <= ptr_after;
                        state <= GAP;
                    end
                end
                IDLE, GAP: begin
                    if (win_valid) begin
                        gnt_o <= {{(N-1){1'b0}}, 1'b1} << winner;
                        sel_o <= winner;
                        state <= OWN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt_o <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios plus randomized request traffic, all
// compared against a cycle-level behavioural model of the round-robin rules.
module tb_mux_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 16;
    localparam int SW       = 2;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt_o;
    logic [SW-1:0] sel_o;
    logic          busy_o;
    logic          timeout_o;

    int checks;
    int errors;

    // Behavioural model: current owner (-1 none), last select, next search start, owned-cycle count.
    int m_owner;
    int m_sel;
    int m_next;
    int m_len;
    bit m_to;

    int wait_cnt [N];
    int max_wait;

    mux_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .gnt_o     (gnt_o),
        .sel_o     (sel_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_owner = -1;
        m_sel   = 0;
        m_next  = 0;
        m_len   = 0;
        m_to    = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // One clock edge of the arbitration rules, given the request vector sampled at that edge.
    task automatic modelStep(input logic [N-1:0] r);
        int c;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_next  = (m_owner + 1) % N;
                m_owner = -1;
            end else if (TIMEOUT_ON && m_len == HOLD_MAX) begin
                m_to    = 1'b1;
                m_next  = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_len++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_next + k) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    m_len   = 1;
                    break;
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [31:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        checkOutput({tag, "_gnt"}, 32'(gnt_o), exp_gnt);
        checkOutput({tag, "_sel"}, 32'(sel_o), 32'(m_sel));
        checkOutput({tag, "_busy"}, 32'(busy_o), (m_owner >= 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'(m_to));
    endtask

    // Present a request vector, let one edge sample it, then compare all outputs 1ns later.
    task automatic applyStimulus(input logic [N-1:0] next_req, input string tag);
        req = next_req;
        @(posedge clk);
        modelStep(req);
        #1;
        checkAll(tag);
    endtask

    // Assert reset between edges and check that the grant drops without waiting for a clock.
    task automatic doReset(input string tag);
        rst = 1'b1;
        req = '0;
        #1;
        checkOutput({tag, "_async_gnt"}, 32'(gnt_o), 32'd0);
        checkOutput({tag, "_async_sel"}, 32'(sel_o), 32'd0);
        checkOutput({tag, "_async_busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_async_timeout"}, 32'(timeout_o), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int          q_order[$];
        int          zeros;
        int          hi_cnt;
        int          to_cnt;
        bit          seen3;
        bit          prev_busy;
        logic [N-1:0] nx;

        checks   = 0;
        errors   = 0;
        max_wait = 0;
        rst      = 1'b1;
        req      = '0;
        modelReset();
        #2;
        checkOutput("por_gnt", 32'(gnt_o), 32'd0);
        checkOutput("por_sel", 32'(sel_o), 32'd0);
        checkOutput("por_busy", 32'(busy_o), 32'd0);
        checkOutput("por_timeout", 32'(timeout_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single request");
        applyStimulus(4'b0100, "single_grant");
        checkOutput("single_gnt", 32'(gnt_o), 32'h4);
        checkOutput("single_sel", 32'(sel_o), 32'd2);
        applyStimulus(4'b0000, "single_drop");
        checkOutput("single_drop_gnt", 32'(gnt_o), 32'd0);
        checkOutput("single_drop_sel", 32'(sel_o), 32'd2);
        applyStimulus(4'b0000, "single_idle");
        applyStimulus(4'b0000, "single_idle2");

        $display("[TB] reset mid-grant");
        applyStimulus(4'b0100, "rstmid_grant");
        applyStimulus(4'b0100, "rstmid_hold");
        checkOutput("rstmid_owner2", 32'(gnt_o), 32'h4);
        doReset("rstmid");
        applyStimulus(4'b0000, "rstmid_idle");
        applyStimulus(4'b0000, "rstmid_idle2");
        checkOutput("rstmid_stays_idle", 32'(busy_o), 32'd0);

        $display("[TB] round robin");
        zeros     = 0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            nx = 4'b1111;
            if (m_owner >= 0 && m_len == 3) nx[m_owner] = 1'b0;
            applyStimulus(nx, "rr");
            if (busy_o && !prev_busy) begin
                for (int i = 0; i < N; i++) if (gnt_o[i]) q_order.push_back(i);
                if (q_order.size() > 1) checkOutput("rr_gap_len", 32'(zeros), 32'd1);
                zeros = 0;
            end else if (!busy_o) begin
                zeros++;
            end
            prev_busy = busy_o;
        end
        checkOutput("rr_grant_count", 32'(q_order.size()), 32'd5);
        for (int i = 0; i < 5 && i < q_order.size(); i++)
            checkOutput("rr_order", 32'(q_order[i]), 32'(i % N));
        applyStimulus(4'b0000, "rr_release");
        applyStimulus(4'b0000, "rr_idle");

        $display("[TB] wrap priority");
        applyStimulus(4'b0100, "wrap_own2");
        checkOutput("wrap_own2_gnt", 32'(gnt_o), 32'h4);
        applyStimulus(4'b0011, "wrap_gap");
        checkOutput("wrap_gap_gnt", 32'(gnt_o), 32'd0);
        applyStimulus(4'b0011, "wrap_grant0");
        checkOutput("wrap_grant0_gnt", 32'(gnt_o), 32'h1);
        checkOutput("wrap_grant0_sel", 32'(sel_o), 32'd0);
        applyStimulus(4'b0010, "wrap_release0");
        applyStimulus(4'b0010, "wrap_grant1");
        checkOutput("wrap_grant1_gnt", 32'(gnt_o), 32'h2);
        applyStimulus(4'b0000, "wrap_release1");
        applyStimulus(4'b0000, "wrap_idle");

        $display("[TB] late join");
        seen3 = 1'b0;
        applyStimulus(4'b0010, "late_grant1");
        checkOutput("late_owner1", 32'(gnt_o), 32'h2);
        applyStimulus(4'b1010, "late_join");
        seen3 |= gnt_o[3];
        applyStimulus(4'b1010, "late_join2");
        seen3 |= gnt_o[3];
        applyStimulus(4'b0010, "late_leave");
        seen3 |= gnt_o[3];
        applyStimulus(4'b0010, "late_hold");
        seen3 |= gnt_o[3];
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(4'b0000, "late_after");
            seen3 |= gnt_o[3];
        end
        checkOutput("late_never_gnt3", 32'(seen3), 32'd0);

`ifdef MUX_ARB_TIMEOUT_EN
        $display("[TB] timeout");
        hi_cnt = 0;
        to_cnt = 0;
        for (int cyc = 0; cyc < 17; cyc++) begin
            applyStimulus(4'b0001, "to_single");
            if (gnt_o[0]) hi_cnt++;
            if (timeout_o) to_cnt++;
        end
        checkOutput("to_grant_len", 32'(hi_cnt), 32'(HOLD_MAX));
        checkOutput("to_pulse_count", 32'(to_cnt), 32'd1);
        applyStimulus(4'b0001, "to_regrant");
        checkOutput("to_regrant_gnt", 32'(gnt_o), 32'h1);
        for (int cyc = 0; cyc < HOLD_MAX; cyc++) applyStimulus(4'b0011, "to_pair");
        checkOutput("to_pair_revoked", 32'(gnt_o), 32'd0);
        checkOutput("to_pair_pulse", 32'(timeout_o), 32'd1);
        applyStimulus(4'b0011, "to_pass");
        checkOutput("to_pass_gnt", 32'(gnt_o), 32'h2);
        applyStimulus(4'b0000, "to_release");
        applyStimulus(4'b0000, "to_idle");
`else
        $display("[TB] unbounded grant");
        hi_cnt = 0;
        to_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            applyStimulus(4'b0001, "hold_long");
            if (gnt_o[0]) hi_cnt++;
            if (timeout_o) to_cnt++;
        end
        checkOutput("hold_long_len", 32'(hi_cnt), 32'd40);
        checkOutput("hold_long_no_timeout", 32'(to_cnt), 32'd0);
        applyStimulus(4'b0000, "hold_release");
        applyStimulus(4'b0000, "hold_idle");
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            nx = req;
            for (int b = 0; b < N; b++) begin
                if (nx[b]) begin
                    if ($urandom_range(0, 5) == 0) nx[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    nx[b] = 1'b1;
                end
            end
            applyStimulus(nx, "rand");
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    wait_cnt[i] = 0;
                end else if (m_owner >= 0 && m_len == 1) begin
                    if (i == m_owner) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                end
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            if ($urandom_range(0, 299) == 0) doReset("rand_rst");
        end
        checkOutput("fair_max_wait_ok", (max_wait <= N - 1) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
